// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store sequencer: word-wide req/ack data memory with wait states and timeout.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  fu3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_word_o,
    output logic [2:0]  load_fu3_o,
    output logic [1:0]  load_addr_o,
    output logic        load_valid_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    // state | meaning
    // IDLE  | waiting for a MEM-stage access
    // REQ   | request on the bus, counting wait states
    // DONE  | one cycle release: load_valid / bus_err pulses
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    state_t          state, state_nx;
    logic [TO_W-1:0] cnt;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic            lat_store;
    logic            err;
    logic            access;
    logic            take;
    logic            ack_hit;
    logic            to_hit;
    logic            trap;

    assign access = mem_read_i | mem_write_i;

`ifdef MISALIGN_TRAP_EN
    logic misal;
    assign misal = (((fu3_i == 3'd1) || (fu3_i == 3'd5)) && addr_i[0])
                 || ((fu3_i == 3'd2) && (addr_i[1:0] != 2'b00));
    assign trap  = (state == IDLE) && access && misal;
`else
    assign trap  = 1'b0;
`endif

    assign misalign_o  = trap;
    assign load_addr_o = lat_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        stall_o      = 1'b0;
        dmem_req     = 1'b0;
        load_valid_o = 1'b0;
        bus_err_o    = 1'b0;
        take         = 1'b0;
        ack_hit      = 1'b0;
        to_hit       = 1'b0;
        case (state)
            IDLE: begin
                if (access && !trap) begin
                    take     = 1'b1;
                    stall_o  = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                stall_o  = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    ack_hit  = 1'b1;
                    state_nx = DONE;
                end else if ((TIMEOUT != 0) && (cnt == TO_VAL)) begin
                    to_hit   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                load_valid_o = !lat_store && !err;
                bus_err_o    = err;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus fields are driven only while requesting so they read zero otherwise.
    always_comb begin
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'd0;
        if (dmem_req) begin
            dmem_we    = lat_store;
            dmem_addr  = {lat_addr[31:2], 2'b00};
            dmem_be    = 4'b1111;
            dmem_wdata = lat_wdata;
            if (lat_store) begin
                case (load_fu3_o)
                    3'd0: begin
                        dmem_be    = 4'b0001 << lat_addr[1:0];
                        dmem_wdata = {4{lat_wdata[7:0]}};
                    end
                    3'd1: begin
                        dmem_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
                        dmem_wdata = {2{lat_wdata[15:0]}};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            err         <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            lat_store   <= 1'b0;
            load_fu3_o  <= 3'd0;
            load_word_o <= 32'd0;
        end else begin
            if (take) begin
                lat_addr   <= addr_i;
                lat_wdata  <= wdata_i;
                lat_store  <= mem_write_i;
                load_fu3_o <= fu3_i;
            end
            if (ack_hit && !lat_store) load_word_o <= dmem_rdata;
            if (to_hit) begin
                err         <= 1'b1;
                load_word_o <= 32'd0;
            end
            if ((state == REQ) && !ack_hit && !to_hit) cnt <= cnt + 1'b1;
            if (state == DONE) begin
                cnt <= '0;
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (default TIMEOUT=16).
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  fu3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_word_o;
    logic [2:0]  load_fu3_o;
    logic [1:0]  load_addr_o;
    logic        load_valid_o, stall_o, bus_err_o, misalign_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .fu3_i(fu3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .load_word_o(load_word_o), .load_fu3_o(load_fu3_o), .load_addr_o(load_addr_o),
        .load_valid_o(load_valid_o), .stall_o(stall_o),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        fu3_i       = 3'd0;
        addr_i      = 32'd0;
        wdata_i     = 32'd0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_be, stall_o, load_valid_o, bus_err_o, misalign_o} !== 10'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {dmem_req, dmem_we, dmem_be, stall_o, load_valid_o, bus_err_o, misalign_o});
        end
        checks++;
        if ({dmem_addr, dmem_wdata, load_word_o, load_fu3_o, load_addr_o} !== 101'd0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h lw=%h fu3=%0d la=%0d exp=0", dmem_addr, dmem_wdata, load_word_o, load_fu3_o, load_addr_o);
        end
        tick();
    endtask

    task automatic test_lw_fast();
        int stalls = 0;
        mem_read_i = 1'b1; fu3_i = 3'd2; addr_i = 32'h100;
        @(negedge clk);
        if (stall_o) stalls++;
        checks++;
        if (dmem_req !== 1'b0) begin failures++; $display("FAIL lw_req_idle got=%b exp=0", dmem_req); end
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        if (stall_o) stalls++;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
            failures++;
            $display("FAIL lw_bus req=%b we=%b be=%b addr=%h exp 1 0 1111 00000100", dmem_req, dmem_we, dmem_be, dmem_addr);
        end
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        if (stall_o) stalls++;
        checks++;
        if ({load_valid_o, load_word_o, load_addr_o, dmem_req} !== {1'b1, 32'hDEADBEEF, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL lw_done lv=%b lw=%h la=%0d req=%b exp 1 deadbeef 0 0", load_valid_o, load_word_o, load_addr_o, dmem_req);
        end
        tick();
        mem_read_i = 1'b0;
        @(negedge clk);
        checks++;
        if (stalls != 2 || load_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL lw_stall_cycles got=%0d lv=%b exp 2 0", stalls, load_valid_o);
        end
        tick();
    endtask

    task automatic test_sb_wait();
        int reqs = 0;
        mem_write_i = 1'b1; fu3_i = 3'd0; addr_i = 32'h203; wdata_i = 32'h000000A5;
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(negedge clk);
            if (dmem_req) reqs++;
            if (i == 0) begin
                checks++;
                if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 4'b1000, 32'h200, 32'hA5A5A5A5}) begin
                    failures++;
                    $display("FAIL sb_bus we=%b be=%b addr=%h wd=%h exp 1 1000 00000200 a5a5a5a5", dmem_we, dmem_be, dmem_addr, dmem_wdata);
                end
            end
            tick();
        end
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (reqs != 4 || {dmem_req, stall_o, load_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL sb_done reqs=%0d req=%b stall=%b lv=%b exp 4 0 0 0", reqs, dmem_req, stall_o, load_valid_o);
        end
        tick();
        mem_write_i = 1'b0;
    endtask

    task automatic test_sh_lhu();
        mem_write_i = 1'b1; fu3_i = 3'd1; addr_i = 32'h002; wdata_i = 32'h00001234;
        tick();
        dmem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 4'b1100, 32'h0, 32'h12341234}) begin
            failures++;
            $display("FAIL sh_bus we=%b be=%b addr=%h wd=%h exp 1 1100 00000000 12341234", dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        tick();
        dmem_ack = 1'b0;
        tick();
        mem_write_i = 1'b0;
        mem_read_i = 1'b1; fu3_i = 3'd5; addr_i = 32'h002; wdata_i = 32'h0;
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h56780000;
        @(negedge clk);
        checks++;
        if ({dmem_we, dmem_be} !== {1'b0, 4'b1111}) begin
            failures++;
            $display("FAIL lhu_bus we=%b be=%b exp 0 1111", dmem_we, dmem_be);
        end
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_valid_o, load_fu3_o, load_addr_o, load_word_o} !== {1'b1, 3'd5, 2'd2, 32'h56780000}) begin
            failures++;
            $display("FAIL lhu_done lv=%b fu3=%0d la=%0d lw=%h exp 1 5 2 56780000", load_valid_o, load_fu3_o, load_addr_o, load_word_o);
        end
        tick();
        mem_read_i = 1'b0;
    endtask

    task automatic test_store_priority();
        mem_read_i = 1'b1; mem_write_i = 1'b1; fu3_i = 3'd2; addr_i = 32'h10; wdata_i = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_we, dmem_be, dmem_wdata} !== {1'b1, 4'b1111, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL both_bus we=%b be=%b wd=%h exp 1 1111 cafef00d", dmem_we, dmem_be, dmem_wdata);
        end
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (load_valid_o !== 1'b0 || load_word_o !== 32'h56780000) begin
            failures++;
            $display("FAIL both_done lv=%b lw=%h exp 0 56780000", load_valid_o, load_word_o);
        end
        tick();
        mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    task automatic test_timeout();
        int reqs = 0;
        mem_read_i = 1'b1; fu3_i = 3'd2; addr_i = 32'h40;
        tick();
        @(negedge clk);
        while (dmem_req === 1'b1 && reqs < 40) begin
            reqs++;
            @(negedge clk);
        end
        checks++;
        if (reqs != 17) begin failures++; $display("FAIL to_req_cycles got=%0d exp=17", reqs); end
        checks++;
        if ({bus_err_o, stall_o, load_word_o} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL to_done err=%b stall=%b lw=%h exp 1 0 00000000", bus_err_o, stall_o, load_word_o);
        end
        @(posedge clk); #1;
        mem_read_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_err_o, stall_o, dmem_req} !== 3'b000) begin
            failures++;
            $display("FAIL to_idle err=%b stall=%b req=%b exp 000", bus_err_o, stall_o, dmem_req);
        end
        tick();
    endtask

    task automatic test_reset_mid_req();
        mem_read_i = 1'b1; fu3_i = 3'd2; addr_i = 32'h80;
        tick();
        tick();
        rst = 1'b1; mem_read_i = 1'b0;
        tick();
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
        @(negedge clk);
        checks++;
        if ({dmem_req, stall_o, load_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid req=%b stall=%b lv=%b exp 000", dmem_req, stall_o, load_valid_o);
        end
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({load_valid_o, load_word_o, dmem_req} !== {1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL rst_late_ack lv=%b lw=%h req=%b exp 0 00000000 0", load_valid_o, load_word_o, dmem_req);
        end
        tick();
    endtask

    task automatic test_misaligned();
        mem_read_i = 1'b1; fu3_i = 3'd2; addr_i = 32'h101;
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        checks++;
        if ({misalign_o, stall_o, dmem_req} !== 3'b100) begin
            failures++;
            $display("FAIL mis_trap mis=%b stall=%b req=%b exp 100", misalign_o, stall_o, dmem_req);
        end
        tick();
        mem_read_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({misalign_o, dmem_req, load_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL mis_after mis=%b req=%b lv=%b exp 000", misalign_o, dmem_req, load_valid_o);
        end
        tick();
`else
        @(negedge clk);
        checks++;
        if ({misalign_o, stall_o} !== 2'b01) begin
            failures++;
            $display("FAIL mis_idle mis=%b stall=%b exp 01", misalign_o, stall_o);
        end
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h100, 4'b1111}) begin
            failures++;
            $display("FAIL mis_bus req=%b addr=%h be=%b exp 1 00000100 1111", dmem_req, dmem_addr, dmem_be);
        end
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_valid_o, load_word_o, load_addr_o} !== {1'b1, 32'h0BADF00D, 2'd1}) begin
            failures++;
            $display("FAIL mis_done lv=%b lw=%h la=%0d exp 1 0badf00d 1", load_valid_o, load_word_o, load_addr_o);
        end
        tick();
        mem_read_i = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_lw_fast();
        test_sb_wait();
        test_sh_lhu();
        test_store_priority();
        test_timeout();
        test_reset_mid_req();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store sequencer between the pipeline MEM stage and a word-wide data memory with a req/ack handshake and variable wait states.
- Presents word-aligned requests with byte enables and lane-replicated store data.
- Stalls the pipeline until the memory acknowledges or a timeout fires.
- Returns the raw read word plus funct3 and address low bits, which the load extraction unit uses for byte/half selection and sign extension.

Parameters:
TIMEOUT, 16, cycles in REQ without dmem_ack before a bus error; 0 disables the timeout
TO_W, 8, width of the timeout counter; TIMEOUT must be below 2**TO_W

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
mem_read_i  in  1  MEM-stage instruction is a load
mem_write_i  in  1  MEM-stage instruction is a store
fu3_i  in  3  funct3 of the MEM-stage instruction
addr_i  in  32  effective byte address
wdata_i  in  32  store source register value
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  memory completes the request this cycle
dmem_rdata  in  32  read word, valid when dmem_ack=1
load_word_o  out  32  raw read word to the load unit
load_fu3_o  out  3  latched funct3 to the load unit
load_addr_o  out  2  latched addr[1:0] to the load unit
load_valid_o  out  1  one-cycle pulse when load_word_o is final for the current load
stall_o  out  1  freeze PC and pipeline registers
bus_err_o  out  1  one-cycle pulse: the access timed out
misalign_o  out  1  one-cycle pulse: misaligned access trapped (optional feature)

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, timeout counter=0.
  - load_word_o=0, load_fu3_o=0, load_addr_o=0.
  - dmem_req=0, dmem_we=0, dmem_be=0, dmem_wdata=0, dmem_addr=0.
  - load_valid_o=0, bus_err_o=0, misalign_o=0.
- Access detection:
  - access = mem_read_i | mem_write_i.
  - If both are asserted, the access is a store.
- States:
  - IDLE: on access, latch addr_i, fu3_i, wdata_i and the store flag, then go to REQ. dmem_ack in IDLE is ignored.
  - REQ: drive dmem_req=1 from the latched values. On dmem_ack, capture dmem_rdata into load_word_o (loads only) and go to DONE. When the counter equals TIMEOUT (TIMEOUT!=0) without ack, set the error flag, load_word_o=0, go to DONE. Otherwise increment the counter. dmem_req drops the cycle after ack.
  - DONE: stall_o=0. load_valid_o=1 for loads. bus_err_o=1 if the error flag is set. Clear the counter and flag, then go to IDLE unconditionally, which lets the pipeline advance.
- stall_o is combinational: (IDLE & access) | REQ. The pipeline holds its MEM-stage inputs stable while stalled.
- Minimum latency: access seen in IDLE at cycle 0, request at cycle 1, ack at cycle 1 gives DONE at cycle 2. Total 2 stall cycles.
- Byte enables and store data (a = latched addr[1:0]):
  - Loads: be=1111, we=0.
  - sb (fu3=0): be=0001<<a, wdata={4{wdata[7:0]}}.
  - sh (fu3=1): be = a[1] ? 1100 : 0011, wdata={2{wdata[15:0]}}.
  - sw (fu3=2) and any other fu3: be=1111, wdata=wdata_i.
- load_word_o, load_fu3_o and load_addr_o hold their values until the next access.
- Misaligned accesses: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
- Reset mid-REQ: the state returns to IDLE and dmem_req falls after that edge. A late ack is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned access in IDLE does not leave IDLE and issues no dmem_req. misalign_o=1 for that one cycle, stall_o=0, load_valid_o=0. Latched registers are not updated.
- Undefined: misalign_o is tied to 0. A misaligned access proceeds as an aligned word access using the lane rules above, so the address low bits only select lanes.

Test Plan:
1. lw addr=0x100, memory acks on the first REQ cycle with rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, stall high 2 cycles, load_valid pulse with load_word_o=0xDEADBEEF, load_addr_o=0.
2. sb addr=0x203, wdata=0x000000A5, ack after 3 wait cycles -> dmem_addr=0x200, be=1000, dmem_wdata=0xA5A5A5A5, we=1, req held 4 cycles, no load_valid.
3. sh addr=0x002, wdata=0x1234 -> be=1100, wdata=0x12341234. Then lhu addr=0x002 -> load_fu3_o=5, load_addr_o=2.
4. TIMEOUT=16, lw with dmem_ack never asserted -> req high 17 cycles, then bus_err_o pulse, load_word_o=0, return to IDLE.
5. rst asserted on the 2nd REQ cycle, ack arrives one cycle later -> state IDLE, dmem_req=0, load_valid stays 0, load_word_o=0.
6. With MISALIGN_TRAP_EN, lw addr=0x101 -> misalign_o pulse, no dmem_req, stall_o=0. Without it -> dmem_addr=0x100, be=1111, normal completion.
